input_action_queue: RTL and testbench

Consumer end of the player input path. Collects single-cycle action pulses from the per-button delayed-auto-shift FSMs and returns a per-action `action_valid` to each of them. Arbitrates simultaneous actions into a small ordered queue and hands one action code at a time to the game engine over a req/ack handshake. Each action has at most one instance outstanding, so a held button cannot flood the engine.

---
 rtl/input_action_queue_pkg.sv | 22 ++
 rtl/input_action_queue_fifo.sv | 83 ++++++++
 rtl/input_action_queue.sv | 127 ++++++++++++
 tb/tb_input_action_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/input_action_queue_pkg.sv
// Shared game definitions for the player input path: action codes,
// the channel count and a width helper.
package input_action_queue_pkg;

  localparam int NUM_ACTIONS = 7;

  typedef enum logic [2:0] {
    MV_LEFT   = 3'd0,
    MV_RIGHT  = 3'd1,
    ROT_CW    = 3'd2,
    ROT_CCW   = 3'd3,
    SOFT_DROP = 3'd4,
    HARD_DROP = 3'd5,
    HOLD      = 3'd6
  } action_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_action_queue_fifo.sv
// action_fifo: small synchronous FIFO holding action codes. Pushes into a
// full FIFO are dropped even if a pop happens on the same edge; pops from an
// empty FIFO are ignored. clr empties the FIFO synchronously.
module action_fifo
  import input_action_queue_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           dout
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_s, rd_en_s;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == {CNT_W{1'b0}});
  assign count   = cnt_q;
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign dout    = empty ? {WIDTH{1'b0}} : mem_q[rd_q];

  // Next-state for storage, pointers (wrapping at DEPTH) and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = {PTR_W{1'b0}};
      rd_d  = {PTR_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_d[wr_q] = din;
        wr_d = (wr_q == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : wr_q + 1'b1;
      end else begin
        wr_d = wr_q;
      end
      if (rd_en_s) begin
        rd_d = (rd_q == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : rd_q + 1'b1;
      end else begin
        rd_d = rd_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_q  <= {PTR_W{1'b0}};
      rd_q  <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/input_action_queue.sv
// input_action_queue: captures action pulses from the DAS FSMs, allows one
// outstanding instance per action, arbitrates pending actions into an
// ordered queue and presents the head to the engine over req/ack.
// Build option: ARB_ROUND_ROBIN_EN selects a round-robin arbiter; otherwise
// the lowest pending index wins.
module input_action_queue
  import input_action_queue_pkg::*;
#(
  parameter int NUM_ACTIONS = input_action_queue_pkg::NUM_ACTIONS,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [NUM_ACTIONS-1:0]         action_pulse,
  output logic [NUM_ACTIONS-1:0]         action_valid,
  input  logic                           accept_en,
  input  logic                           flush,
  output logic                           act_req,
  output logic [$clog2(NUM_ACTIONS)-1:0] act_code,
  input  logic                           act_ack
);

  localparam int CODE_W = $clog2(NUM_ACTIONS);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH+1);

  logic [NUM_ACTIONS-1:0] pending_q, pending_d, inflight_q, inflight_d;
  logic [NUM_ACTIONS-1:0] capture_s, grant_oh_s, pop_oh_s;
  logic [CODE_W-1:0]      grant_idx_s, head_s;
  logic [CNT_W-1:0]       count_s;
  logic                   grant_s, pop_s, fifo_full_s, fifo_empty_s;

  assign action_valid = {NUM_ACTIONS{accept_en}} & ~inflight_q;
  assign capture_s    = action_pulse & action_valid & {NUM_ACTIONS{!flush}};
  assign grant_s      = (|pending_q) && !fifo_full_s && !flush;
  assign pop_s        = act_ack && !fifo_empty_s && !flush;
  assign grant_oh_s   = grant_s ? (NUM_ACTIONS'(1) << grant_idx_s) : {NUM_ACTIONS{1'b0}};
  assign pop_oh_s     = pop_s ? (NUM_ACTIONS'(1) << head_s) : {NUM_ACTIONS{1'b0}};
  assign act_req      = (count_s != {CNT_W{1'b0}});

`ifdef ARB_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_q, last_d;
  logic              found_s;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_idx_s = {CODE_W{1'b0}};
    found_s     = 1'b0;
    for (int k = 0; k < NUM_ACTIONS; k++) begin
      if (!found_s && pending_q[(int'(last_q) + 1 + k) % NUM_ACTIONS]) begin
        found_s     = 1'b1;
        grant_idx_s = CODE_W'((int'(last_q) + 1 + k) % NUM_ACTIONS);
      end else begin
        found_s = found_s;
      end
    end
    if (flush) begin
      last_d = CODE_W'(NUM_ACTIONS-1);
    end else if (grant_s) begin
      last_d = grant_idx_s;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant pointer; reset value makes the first search start at 0.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) last_q <= CODE_W'(NUM_ACTIONS-1);
    else        last_q <= last_d;
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    grant_idx_s = {CODE_W{1'b0}};
    for (int i = NUM_ACTIONS-1; i >= 0; i--) begin
      if (pending_q[i]) grant_idx_s = CODE_W'(i);
      else              grant_idx_s = grant_idx_s;
    end
  end
`endif

  // Per-channel bookkeeping: capture sets, grant clears pending, pop clears inflight.
  always_comb begin
    if (flush) begin
      pending_d  = {NUM_ACTIONS{1'b0}};
      inflight_d = {NUM_ACTIONS{1'b0}};
    end else begin
      pending_d  = (pending_q & ~grant_oh_s) | capture_s;
      inflight_d = (inflight_q & ~pop_oh_s) | capture_s;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pending_q  <= {NUM_ACTIONS{1'b0}};
      inflight_q <= {NUM_ACTIONS{1'b0}};
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  action_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .clr   (flush),
    .push  (grant_s),
    .din   (grant_idx_s),
    .pop   (pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s),
    .dout  (head_s)
  );

  if (NUM_ACTIONS == input_action_queue_pkg::NUM_ACTIONS) begin : g_typed_code
    action_t head_act_s;
    assign head_act_s = action_t'(head_s);
    assign act_code   = head_act_s;
  end else begin : g_raw_code
    assign act_code = head_s;
  end

endmodule

// File: tb/tb_input_action_queue.sv
// Directed bench for input_action_queue: a default-depth instance and a
// depth-1 instance for the arbitration-order scenario.
module tb_input_action_queue;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;

  logic [6:0] pulse_a = 7'd0, valid_a;
  logic       accept_a = 1'b1, flush_a = 1'b0, ack_a = 1'b0, req_a;
  logic [2:0] code_a;

  logic [6:0] pulse_b = 7'd0, valid_b;
  logic       accept_b = 1'b1, flush_b = 1'b0, ack_b = 1'b0, req_b;
  logic [2:0] code_b;

  int n_vec = 0;
  int n_err = 0;
  int got_n;
  logic [2:0] got [3];
  logic [2:0] exp_order [3];

  always #5 clk = ~clk;

  input_action_queue #(.NUM_ACTIONS(7), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst_l(rst_l), .action_pulse(pulse_a), .action_valid(valid_a),
    .accept_en(accept_a), .flush(flush_a), .act_req(req_a), .act_code(code_a),
    .act_ack(ack_a)
  );

  input_action_queue #(.NUM_ACTIONS(7), .QUEUE_DEPTH(1)) dut1 (
    .clk(clk), .rst_l(rst_l), .action_pulse(pulse_b), .action_valid(valid_b),
    .accept_en(accept_b), .flush(flush_b), .act_req(req_b), .act_code(code_b),
    .act_ack(ack_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_req", req_a, 0);
    chk("rst_code", code_a, 0);
    chk("rst_valid", valid_a, 7'h7f);
    accept_a = 1'b0;
    #1;
    chk("rst_valid_noacc", valid_a, 7'h00);
    accept_a = 1'b1;
    #10 rst_l = 1'b1;
    step();

    // Single pulse on channel 0 with ack held high
    ack_a = 1'b1;
    pulse_a = 7'b0000001;
    step();
    pulse_a = 7'd0;
    chk("t1_req_n1", req_a, 0);
    chk("t1_valid0_n1", valid_a[0], 0);
    step();
    chk("t1_req_n2", req_a, 1);
    chk("t1_code_n2", code_a, 0);
    chk("t1_valid0_n2", valid_a[0], 0);
    step();
    chk("t1_req_n3", req_a, 0);
    chk("t1_valid_n3", valid_a, 7'h7f);

    // Channels 1, 3, 5 together
    pulse_a = 7'b0101010;
    step();
    pulse_a = 7'd0;
    chk("t2_req_n1", req_a, 0);
    step();
    chk("t2_req_a", req_a, 1);
    chk("t2_code_a", code_a, 1);
    step();
    chk("t2_code_b", code_a, 3);
    step();
    chk("t2_code_c", code_a, 5);
    step();
    chk("t2_req_end", req_a, 0);
    chk("t2_valid_end", valid_a, 7'h7f);

    // Stall with four entries queued, pulse on inflight channel ignored
    ack_a = 1'b0;
    pulse_a = 7'b0010111;
    step();
    pulse_a = 7'd0;
    step();
    chk("t3_req", req_a, 1);
    chk("t3_code", code_a, 0);
    chk("t3_valid", valid_a, 7'b1101000);
    for (int i = 0; i < 20; i++) begin
      pulse_a = (i == 5) ? 7'b0000010 : 7'd0;
      step();
      chk("t3_hold_req", req_a, 1);
      chk("t3_hold_code", code_a, 0);
    end
    pulse_a = 7'd0;
    chk("t3_valid_hold", valid_a, 7'b1101000);
    ack_a = 1'b1;
    #1;
    chk("t3_drain0", code_a, 0);
    step();
    chk("t3_drain1", code_a, 1);
    step();
    chk("t3_drain2", code_a, 2);
    step();
    chk("t3_drain3", code_a, 4);
    step();
    chk("t3_req_end", req_a, 0);

    // Flush with three entries queued and a pulse on channel 6
    ack_a = 1'b0;
    pulse_a = 7'b0000111;
    step();
    pulse_a = 7'd0;
    step();
    step();
    step();
    chk("t4_req_pre", req_a, 1);
    flush_a = 1'b1;
    pulse_a = 7'b1000000;
    ack_a = 1'b1;
    step();
    flush_a = 1'b0;
    pulse_a = 7'd0;
    ack_a = 1'b0;
    chk("t4_req_post", req_a, 0);
    chk("t4_valid_post", valid_a, 7'h7f);
    step();
    chk("t4_req_post2", req_a, 0);
    step();
    chk("t4_req_post3", req_a, 0);
    chk("t4_valid_post3", valid_a, 7'h7f);

    // accept_en low with two entries queued
    pulse_a = 7'b0011000;
    step();
    pulse_a = 7'd0;
    step();
    step();
    chk("t5_req", req_a, 1);
    chk("t5_code", code_a, 3);
    accept_a = 1'b0;
    #1;
    chk("t5_valid_off", valid_a, 7'h00);
    pulse_a = 7'b0100001;
    ack_a = 1'b1;
    #1;
    chk("t5_drain0", code_a, 3);
    step();
    pulse_a = 7'd0;
    chk("t5_req1", req_a, 1);
    chk("t5_drain1", code_a, 4);
    step();
    chk("t5_req_end", req_a, 0);
    step();
    chk("t5_req_end2", req_a, 0);
    chk("t5_valid_off2", valid_a, 7'h00);
    accept_a = 1'b1;
    #1;
    chk("t5_valid_on", valid_a, 7'h7f);

    // Depth-1 instance: arbitration order
`ifdef ARB_ROUND_ROBIN_EN
    exp_order[0] = 3'd2; exp_order[1] = 3'd3; exp_order[2] = 3'd0;
`else
    exp_order[0] = 3'd2; exp_order[1] = 3'd0; exp_order[2] = 3'd3;
`endif
    pulse_b = 7'b0001100;
    step();
    pulse_b = 7'd0;
    step();
    step();
    pulse_b = 7'b0000001;
    step();
    pulse_b = 7'd0;
    chk("t6_stall_req", req_b, 1);
    chk("t6_stall_code", code_b, 2);
    step();
    ack_b = 1'b1;
    got_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_b && got_n < 3) begin
        got[got_n] = code_b;
        got_n++;
      end
      step();
    end
    chk("t6_count", got_n, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_n) chk("t6_order", got[i], exp_order[i]);
    end
    chk("t6_req_end", req_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
